// File: rtl/ram32_fifo_reader.sv
// ----------------------------------------------------------------------------
// ram32_fifo_reader
//
// 32-deep first-word-fall-through FIFO. The words are stored in a 32 x WIDTH
// distributed RAM, which is written synchronously and read asynchronously.
// A registered output stage sits in front of the RAM and holds the head word,
// so the consumer always sees registered data.
//
// Parameters
//   WIDTH   data width in bits (1..64)
//   INIT    power-up value of every RAM word and of RD_DATA before reset
//
// Ports
//   CLK      in   single clock, rising edge
//   RST      in   asynchronous active-high reset
//   WR_EN    in   write request
//   WR_DATA  in   write data
//   FULL     out  occupancy is 32
//   RD_EN    in   consume the head word shown on RD_DATA
//   RD_DATA  out  registered head word, valid while EMPTY is low
//   EMPTY    out  no word is presented on RD_DATA
//   COUNT    out  occupancy 0..32 (RAM words plus the output register)
//   OVF      out  sticky: a write was attempted while FULL
//   UDF      out  sticky: a read was attempted while EMPTY
// ----------------------------------------------------------------------------
module ram32_fifo_reader #(
   parameter int          WIDTH = 8,
   parameter logic [63:0] INIT  = 64'd0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WR_EN,
   input  logic [WIDTH-1:0] WR_DATA,
   output logic             FULL,
   input  logic             RD_EN,
   output logic [WIDTH-1:0] RD_DATA,
   output logic             EMPTY,
   output logic [5:0]       COUNT,
   output logic             OVF,
   output logic             UDF
);

   // Storage and output register power up to INIT; reset never touches the RAM.
   logic [WIDTH-1:0] mem_r [0:31] = '{default: INIT[WIDTH-1:0]};
   logic [WIDTH-1:0] rd_data_r    = INIT[WIDTH-1:0];

   logic [4:0] wr_ptr_r;
   logic [4:0] rd_ptr_r;
   logic [5:0] ram_cnt_r;
   logic       out_vld_r;
   logic [5:0] count_r;
   logic       full_r;
   logic       ovf_r;
   logic       udf_r;

   logic       wr_acc_s;
   logic       rd_acc_s;
   logic       load_s;
   logic [5:0] ram_cnt_nxt_s;
   logic       out_vld_nxt_s;
   logic [5:0] count_nxt_s;

   // Acceptance, output-stage load and next-state occupancy.
   always_comb begin
      wr_acc_s      = 1'b0;
      rd_acc_s      = 1'b0;
      load_s        = 1'b0;
      ram_cnt_nxt_s = ram_cnt_r;
      out_vld_nxt_s = out_vld_r;
      count_nxt_s   = count_r;

      // FULL is the registered flag, so a read in the same cycle cannot
      // make room for a write; that write is dropped.
      wr_acc_s = WR_EN & ~full_r;
      rd_acc_s = RD_EN & out_vld_r;
      // Refill the output register whenever it is empty or being consumed.
      load_s   = (ram_cnt_r != 6'd0) & (~out_vld_r | rd_acc_s);

      ram_cnt_nxt_s = ram_cnt_r + {5'd0, wr_acc_s} - {5'd0, load_s};

      if (load_s) begin
         out_vld_nxt_s = 1'b1;
      end else if (rd_acc_s) begin
         out_vld_nxt_s = 1'b0;
      end else begin
         out_vld_nxt_s = out_vld_r;
      end

      count_nxt_s = ram_cnt_nxt_s + {5'd0, out_vld_nxt_s};
   end

   // RAM write port. While the output register is valid ram_cnt stays at or
   // below 31, so the written word is never the one being read this cycle.
   always_ff @(posedge CLK) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= WR_DATA;
      end
   end

   // Pointers, occupancy, output stage and sticky error flags.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_r  <= 5'd0;
         rd_ptr_r  <= 5'd0;
         ram_cnt_r <= 6'd0;
         out_vld_r <= 1'b0;
         count_r   <= 6'd0;
         full_r    <= 1'b0;
         ovf_r     <= 1'b0;
         udf_r     <= 1'b0;
         rd_data_r <= '0;
      end else begin
         ram_cnt_r <= ram_cnt_nxt_s;
         out_vld_r <= out_vld_nxt_s;
         count_r   <= count_nxt_s;
         full_r    <= (count_nxt_s == 6'd32);

         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + 5'd1;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end

         // Asynchronous RAM read feeds the output register directly.
         if (load_s) begin
            rd_data_r <= mem_r[rd_ptr_r];
            rd_ptr_r  <= rd_ptr_r + 5'd1;
         end else begin
            rd_data_r <= rd_data_r;
            rd_ptr_r  <= rd_ptr_r;
         end

         if (WR_EN & full_r) begin
            ovf_r <= 1'b1;
         end else begin
            ovf_r <= ovf_r;
         end

         if (RD_EN & ~out_vld_r) begin
            udf_r <= 1'b1;
         end else begin
            udf_r <= udf_r;
         end
      end
   end

   assign FULL    = full_r;
   assign RD_DATA = rd_data_r;
   assign EMPTY   = ~out_vld_r;
   assign COUNT   = count_r;
   assign OVF     = ovf_r;
   assign UDF     = udf_r;

endmodule

// File: tb/tb_ram32_fifo_reader.sv
// ----------------------------------------------------------------------------
// tb_ram32_fifo_reader
//
// Self-checking bench for ram32_fifo_reader. The reference model is a queue
// of words, each tagged with the clock edge at which it was written. A word
// is presented on RD_DATA once it is at the head of the queue and at least
// one edge has passed since it was written.
// ----------------------------------------------------------------------------
module tb_ram32_fifo_reader;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         WR_EN = 1'b0;
   logic [W-1:0] WR_DATA = '0;
   logic         RD_EN = 1'b0;
   logic         FULL;
   logic [W-1:0] RD_DATA;
   logic         EMPTY;
   logic [5:0]   COUNT;
   logic         OVF;
   logic         UDF;

   ram32_fifo_reader #(.WIDTH(W), .INIT(64'd0)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .WR_EN   (WR_EN),
      .WR_DATA (WR_DATA),
      .FULL    (FULL),
      .RD_EN   (RD_EN),
      .RD_DATA (RD_DATA),
      .EMPTY   (EMPTY),
      .COUNT   (COUNT),
      .OVF     (OVF),
      .UDF     (UDF)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [W-1:0] m_data[$];
   int           m_edge[$];
   int           edge_n = 0;
   logic         m_ovf = 1'b0;
   logic         m_udf = 1'b0;
   logic [W-1:0] m_rd  = '0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit m_pres();
      return (m_data.size() != 0) && (m_edge[0] < edge_n);
   endfunction

   task automatic check_all();
      chk("empty",   {63'd0, EMPTY}, {63'd0, !m_pres()});
      chk("count",   {58'd0, COUNT}, 64'(m_data.size()));
      chk("full",    {63'd0, FULL},  {63'd0, (m_data.size() == 32)});
      chk("ovf",     {63'd0, OVF},   {63'd0, m_ovf});
      chk("udf",     {63'd0, UDF},   {63'd0, m_udf});
      chk("rd_data", 64'(RD_DATA),   64'(m_rd));
   endtask

   // One clock cycle of stimulus, model update and full output comparison.
   task automatic cycle(input bit wr, input logic [W-1:0] d, input bit rd);
      bit full_b;
      bit pres_b;
      WR_EN   = wr;
      WR_DATA = d;
      RD_EN   = rd;
      full_b  = (m_data.size() == 32);
      pres_b  = m_pres();
      @(posedge CLK);
      edge_n++;
      if (wr && full_b) m_ovf = 1'b1;
      if (rd && !pres_b) m_udf = 1'b1;
      if (rd && pres_b) begin
         void'(m_data.pop_front());
         void'(m_edge.pop_front());
      end
      if (wr && !full_b) begin
         m_data.push_back(d);
         m_edge.push_back(edge_n);
      end
      if (m_pres()) m_rd = m_data[0];
      #1;
      check_all();
   endtask

   // Mid-cycle asynchronous reset, checked before any clock edge.
   task automatic do_reset();
      WR_EN = 1'b0;
      RD_EN = 1'b0;
      #2 RST = 1'b1;
      #1;
      m_data.delete();
      m_edge.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rd  = '0;
      chk("rst_empty", {63'd0, EMPTY}, 64'd1);
      chk("rst_count", {58'd0, COUNT}, 64'd0);
      chk("rst_full",  {63'd0, FULL},  64'd0);
      chk("rst_ovf",   {63'd0, OVF},   64'd0);
      chk("rst_udf",   {63'd0, UDF},   64'd0);
      chk("rst_data",  64'(RD_DATA),   64'd0);
      #1 RST = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && m_data.size() != 0; i++) cycle(1'b0, '0, 1'b1);
      chk("drained", {58'd0, COUNT}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wrote;
      int cyc;
      bit w;
      bit r;

      // Power-on reset.
      #1 RST = 1'b1;
      #2;
      chk("por_empty", {63'd0, EMPTY}, 64'd1);
      chk("por_count", {58'd0, COUNT}, 64'd0);
      chk("por_data",  64'(RD_DATA),   64'd0);
      @(posedge CLK);
      #2 RST = 1'b0;

      // Read while empty: UDF set, nothing else changes.
      cycle(1'b0, '0, 1'b1);
      chk("udf_set",   {63'd0, UDF},   64'd1);
      chk("udf_count", {58'd0, COUNT}, 64'd0);
      chk("udf_data",  64'(RD_DATA),   64'd0);

      // Single word latency.
      cycle(1'b1, 8'h3C, 1'b0);
      chk("lat_count1", {58'd0, COUNT}, 64'd1);
      chk("lat_empty1", {63'd0, EMPTY}, 64'd1);
      cycle(1'b0, '0, 1'b0);
      chk("lat_empty2", {63'd0, EMPTY}, 64'd0);
      chk("lat_data",   64'(RD_DATA),   64'h3C);
      cycle(1'b0, '0, 1'b1);
      chk("lat_empty3", {63'd0, EMPTY}, 64'd1);
      chk("lat_count3", {58'd0, COUNT}, 64'd0);

      // Fill to 32, overflow, drain in order.
      for (int i = 0; i < 32; i++) cycle(1'b1, 8'(i), 1'b0);
      chk("fill_full", {63'd0, FULL}, 64'd1);
      cycle(1'b1, 8'hFF, 1'b0);
      chk("fill_ovf",   {63'd0, OVF},   64'd1);
      chk("fill_count", {58'd0, COUNT}, 64'd32);
      for (int i = 0; i < 32; i++) begin
         chk("drain_order", 64'(RD_DATA), 64'(i));
         cycle(1'b0, '0, 1'b1);
      end
      chk("drain_empty", {63'd0, EMPTY}, 64'd1);

      // Read and write at FULL, then steady state at 31.
      for (int i = 0; i < 32; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
      cycle(1'b1, 8'hEE, 1'b1);
      chk("rw_full_count", {58'd0, COUNT}, 64'd31);
      chk("rw_full_full",  {63'd0, FULL},  64'd0);
      for (int i = 0; i < 50; i++) begin
         cycle(1'b1, 8'(8'h80 + i), 1'b1);
         chk("rw31_count", {58'd0, COUNT}, 64'd31);
      end
      drain();

      // Randomized traffic, 100 incrementing words.
      wrote = 0;
      cyc   = 0;
      while (wrote < 100 && cyc < 2000) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         if (w && m_data.size() < 32) begin
            cycle(1'b1, 8'(wrote), r);
            wrote++;
         end else begin
            cycle(w, 8'(wrote), r);
         end
         cyc++;
      end
      chk("rand_budget", 64'(wrote), 64'd100);
      drain();
      chk("udf_sticky", {63'd0, UDF}, 64'd1);

      // Reset with traffic queued, then restart from empty.
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
      chk("pre_rst_count", {58'd0, COUNT}, 64'd10);
      do_reset();
      cycle(1'b1, 8'hA5, 1'b0);
      chk("post_rst_empty", {63'd0, EMPTY}, 64'd1);
      cycle(1'b0, '0, 1'b0);
      chk("post_rst_data",  64'(RD_DATA),   64'hA5);
      chk("post_rst_vld",   {63'd0, EMPTY}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
